instruction_fetch: RTL
======================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter NOP_WORD, default 32'h0000_0000, meaning the instruction driven on flush or reset.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on posedge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port stall  input  1  hazard hold from decode; freezes the IF/ID register and PC advance.
REQ-006 SHALL have port redirect  input  1  taken branch/jump; flushes IF/ID and loads PC.
REQ-007 SHALL have port redirect_target  input  32  new PC when redirect=1.
REQ-008 SHALL have port imem_req  output  1  fetch request to instruction memory.
REQ-009 SHALL have port imem_addr  output  32  fetch address, held stable while imem_req=1 until imem_ready.
REQ-010 SHALL have port imem_rdata  input  32  fetched word, valid only when imem_ready=1.
REQ-011 SHALL have port imem_ready  input  1  completes the outstanding request; may assert in the same cycle as the request (zero wait).
REQ-012 SHALL have port instruction  output  32  registered IF/ID instruction to decode.
REQ-013 SHALL have port pc_out  output  32  registered address of instruction.
REQ-014 SHALL have port pc_plus4  output  32  registered pc_out+4, modulo 2^32.
REQ-015 SHALL have port inst_valid  output  1  1 = instruction is real; 0 = bubble.

Function
REQ-016 SHALL implement a 3-state FSM: FETCH (imem_req=1, imem_addr=pc), DISCARD (imem_req=1, imem_addr=pc; response dropped), BUFFER (imem_req=0; fetched word held in buf).
REQ-017 SHALL drive imem_req and imem_addr combinationally from state and pc only; imem_req SHALL be 0 while reset=1.
REQ-018 FETCH, ready, !redirect, !stall: SHALL load IF/ID {imem_rdata, pc, pc+4, valid=1}; pc <= pc+4; remain in FETCH.
REQ-019 FETCH, ready, !redirect, stall: SHALL capture buf <= imem_rdata; pc unchanged; IF/ID held; go to BUFFER.
REQ-020 FETCH, !ready, !redirect: SHALL hold pc; if !stall, inst_valid <= 0 (bubble); if stall, IF/ID held.
REQ-021 FETCH, redirect, ready: SHALL drop the word; pc <= redirect_target; flush; remain in FETCH.
REQ-022 FETCH, redirect, !ready: SHALL store pend <= redirect_target; flush; go to DISCARD (the outstanding request is never aborted).
REQ-023 DISCARD: on ready SHALL drop the word, set pc <= pend (or redirect_target if redirect is asserted in that same cycle), and go to FETCH; redirect without ready SHALL update pend (latest wins); IF/ID stays flushed.
REQ-024 BUFFER, !stall, !redirect: SHALL load IF/ID {buf, pc, pc+4, valid=1}; pc <= pc+4; go to FETCH.
REQ-025 BUFFER, redirect: SHALL drop buf; pc <= redirect_target; flush; go to FETCH. BUFFER, stall, !redirect: hold all.
REQ-026 Flush SHALL mean instruction <= NOP_WORD, inst_valid <= 0, with pc_out/pc_plus4 unchanged.
REQ-027 Redirect SHALL take priority over stall and ready in every state.
REQ-028 pc+4 SHALL wrap: 32'hFFFF_FFFC+4 = 32'h0000_0000. No alignment checking is performed.
REQ-029 Fetch-to-IF/ID latency SHALL be exactly one clk edge after the edge sampling imem_ready (zero-wait memory: one instruction per cycle).

Reset
REQ-030 On reset=1 at posedge: pc <= RESET_PC, state <= FETCH, instruction <= NOP_WORD, inst_valid <= 0, pc_out <= 0, pc_plus4 <= 0, buf and pend <= 0.
REQ-031 Reset SHALL override redirect, stall and ready; a request in flight when reset is asserted SHALL be abandoned (the memory is reset with the core).

Verification
REQ-032 Zero-wait stream: reset, ready tied 1, rdata=addr^32'hA5A5_0000 -> after reset, pc_out 0,4,8,... one per cycle, inst_valid=1, matching words.
REQ-033 Wait states: ready low 2 cycles per fetch -> two inst_valid=0 bubbles between instructions; imem_addr stable across the wait.
REQ-034 Stall capture: stall=1 on the cycle ready returns the word at 0x10 -> BUFFER; IF/ID unchanged; imem_req=0; on stall release, pc_out=0x10 with the buffered word, then fetch 0x14.
REQ-035 Redirect mid-wait: request to 0x20 outstanding, redirect to 0x100, then redirect to 0x200 before ready -> the 0x20 word is dropped, the next fetch addr is 0x200, and inst_valid=0 throughout.
REQ-036 Redirect with stall: stall=1 and redirect=1 to 0x40 -> flush (instruction=NOP_WORD, inst_valid=0); next fetch addr 0x40.
REQ-037 Wrap/reset: RESET_PC=32'hFFFF_FFFC -> pc_plus4=0 and the next fetch is 0x0; assert reset mid-wait -> next cycle imem_addr=RESET_PC, inst_valid=0.

Source files
------------

// File: rtl/instruction_fetch.sv
// ============================================================================
// Module      : instruction_fetch
// Description : IF stage. Issues in-order fetches and fills the IF/ID register.
//               Handles wait states, decode stalls and branch redirects.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] instruction,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4,
    output logic        inst_valid
);

    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_DISCARD = 2'd1,
        S_BUFFER  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] buf_q, buf_d;
    logic [31:0] pend_q, pend_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic [31:0] pc_plus4_q, pc_plus4_d;
    logic        valid_q, valid_d;

    logic [31:0] w_pc_inc;

    assign w_pc_inc = pc_q + 32'd4;

    // The request is never withdrawn mid-flight except by reset, which also
    // resets the memory, so the address only depends on state and pc.
    assign imem_req  = !reset && ((state_q == S_FETCH) || (state_q == S_DISCARD));
    assign imem_addr = pc_q;

    assign instruction = instr_q;
    assign pc_out      = pc_out_q;
    assign pc_plus4    = pc_plus4_q;
    assign inst_valid  = valid_q;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        buf_d      = buf_q;
        pend_d     = pend_q;
        instr_d    = instr_q;
        pc_out_d   = pc_out_q;
        pc_plus4_d = pc_plus4_q;
        valid_d    = valid_q;

        case (state_q)
            S_FETCH: begin
                if (redirect) begin
                    instr_d = NOP_WORD;
                    valid_d = 1'b0;
                    if (imem_ready) begin
                        pc_d = redirect_target;
                    end else begin
                        pend_d  = redirect_target;
                        state_d = S_DISCARD;
                    end
                end else if (imem_ready) begin
                    if (!stall) begin
                        instr_d    = imem_rdata;
                        pc_out_d   = pc_q;
                        pc_plus4_d = w_pc_inc;
                        valid_d    = 1'b1;
                        pc_d       = w_pc_inc;
                    end else begin
                        buf_d   = imem_rdata;
                        state_d = S_BUFFER;
                    end
                end else if (!stall) begin
                    valid_d = 1'b0;
                end
            end

            S_DISCARD: begin
                instr_d = NOP_WORD;
                valid_d = 1'b0;
                if (imem_ready) begin
                    pc_d    = redirect ? redirect_target : pend_q;
                    state_d = S_FETCH;
                end else if (redirect) begin
                    pend_d = redirect_target;
                end
            end

            S_BUFFER: begin
                if (redirect) begin
                    instr_d = NOP_WORD;
                    valid_d = 1'b0;
                    pc_d    = redirect_target;
                    state_d = S_FETCH;
                end else if (!stall) begin
                    instr_d    = buf_q;
                    pc_out_d   = pc_q;
                    pc_plus4_d = w_pc_inc;
                    valid_d    = 1'b1;
                    pc_d       = w_pc_inc;
                    state_d    = S_FETCH;
                end
            end

            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_FETCH;
            pc_q       <= RESET_PC;
            buf_q      <= 32'd0;
            pend_q     <= 32'd0;
            instr_q    <= NOP_WORD;
            pc_out_q   <= 32'd0;
            pc_plus4_q <= 32'd0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            buf_q      <= buf_d;
            pend_q     <= pend_d;
            instr_q    <= instr_d;
            pc_out_q   <= pc_out_d;
            pc_plus4_q <= pc_plus4_d;
            valid_q    <= valid_d;
        end
    end

endmodule

`default_nettype wire
